// File: rtl/cpu_uart_rx_buffer.sv
// Receive buffer between the UART receiver and the CPU bus: edge-captures bytes into a FIFO
// (macro UART_RX_FIFO_EN) or a single holding register (default), with RXD/CON registers and irq.
module cpu_uart_rx_buffer #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] ADDR_RXD = 32'h4000_001C,
   parameter logic [31:0] ADDR_CON = 32'h4000_0020
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        RX_STATUS,
   input  logic [7:0]  RX_DATA,
   input  logic [31:0] addr,
   input  logic        rd,
   input  logic        wr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

`ifdef UART_RX_FIFO_EN
   localparam int unsigned NENT = DEPTH;
`else
   // DEPTH has no effect here; the buffer is one byte deep.
   localparam int unsigned NENT = (DEPTH > 0) ? 1 : 1;
`endif
   localparam int unsigned CW = $clog2(NENT) + 1;

   logic          st_q;
   logic          push, pop, accept, ovf_set;
   logic          rd_rxd, wr_con;
   logic          full, nonempty;
   logic [CW-1:0] count_q, count_d;
   logic          irq_en_q, irq_en_d;
   logic          ovf_q, ovf_d;
   logic [7:0]    head;
   logic [4:0]    count_field;
   logic          unused_wdata;

   assign unused_wdata = ^{wdata[31:4], wdata[2:1]};

   // st_q resets high so a RX_STATUS already asserted at reset release is not taken as a new byte.
   assign push     = RX_STATUS & ~st_q;
   assign rd_rxd   = rd & (addr == ADDR_RXD);
   assign wr_con   = wr & (addr == ADDR_CON);
   assign full     = (count_q == CW'(NENT));
   assign nonempty = (count_q != '0);
   assign pop      = rd_rxd & nonempty;
   // A pop in the same cycle frees the slot, so a push into a full buffer is still accepted.
   assign accept   = push & (~full | pop);
   assign ovf_set  = push & full & ~pop;

   always_comb begin
      count_d = count_q;
      if (accept && !pop)
         count_d = count_q + 1'b1;
      else if (!accept && pop)
         count_d = count_q - 1'b1;
   end

   always_comb begin
      irq_en_d = irq_en_q;
      ovf_d    = ovf_q;
      if (wr_con) begin
         irq_en_d = wdata[0];
         if (wdata[3])
            ovf_d = 1'b0;
      end
      if (ovf_set)
         ovf_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st_q     <= 1'b1;
         count_q  <= '0;
         irq_en_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         st_q     <= RX_STATUS;
         count_q  <= count_d;
         irq_en_q <= irq_en_d;
         ovf_q    <= ovf_d;
      end
   end

`ifdef UART_RX_FIFO_EN
   localparam int unsigned PW = $clog2(DEPTH);

   logic [PW-1:0]            wptr_q, rptr_q;
   logic [DEPTH-1:0][7:0]    mem_q;

   // Power-of-two DEPTH: natural pointer overflow is the modulo wrap.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
         mem_q  <= '0;
      end else begin
         if (accept) begin
            mem_q[wptr_q] <= RX_DATA;
            wptr_q        <= wptr_q + 1'b1;
         end
         if (pop)
            rptr_q <= rptr_q + 1'b1;
      end
   end

   assign head = mem_q[rptr_q];
`else
   logic [7:0] hold_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         hold_q <= 8'h00;
      else if (accept)
         hold_q <= RX_DATA;
   end

   assign head = hold_q;
`endif

   assign count_field = 5'(count_q);

   always_comb begin
      rdata = 32'h0;
      if (addr == ADDR_RXD)
         rdata = {24'h0, (nonempty ? head : 8'h00)};
      else if (addr == ADDR_CON)
         rdata = {23'h0, count_field, ovf_q, full, nonempty, irq_en_q};
   end

   assign irq = irq_en_q & nonempty;

endmodule

// File: doc/cpu_uart_rx_buffer.md
# cpu_uart_rx_buffer

Downstream consumer of the single-cycle CPU's UART receiver. Captures each completed received byte, signalled by the receiver's `RX_STATUS` / `RX_DATA` pair, into a small FIFO. Exposes the bytes to the CPU as memory-mapped data and control registers and raises an interrupt while data is pending. It sits between the UART receiver and the CPU peripheral bus decoder.

## Interface
Parameters:
- `DEPTH`, 4 — FIFO entries; power of two, 2..16.
- `ADDR_RXD`, 32'h4000001C — address of the receive-data register.
- `ADDR_CON`, 32'h40000020 — address of the control/status register.

Ports:
- `clk` in 1 — system clock; same clock as the UART receiver's `clk`.
- `reset` in 1 — asynchronous, active-low reset.
- `RX_STATUS` in 1 — receiver done flag; level, may stay high for several `clk` cycles per byte.
- `RX_DATA` in 8 — received byte; valid while `RX_STATUS` is high.
- `addr` in 32 — CPU bus address.
- `rd` in 1 — CPU read strobe, one cycle per access.
- `wr` in 1 — CPU write strobe, one cycle per access.
- `wdata` in 32 — CPU write data.
- `rdata` out 32 — combinational read data.
- `irq` out 1 — receive interrupt request.

## Operation
- Edge detect:
  - `st_d` is a register of `RX_STATUS`; reset value is 1, so a `RX_STATUS` already high at reset release is not captured.
  - `push = RX_STATUS & ~st_d`.
- Push: on the clock edge where `push` is 1, `RX_DATA` is written at the write pointer, and the pointer and `count` advance.
- Pop: occurs when `rd` is 1, `addr == ADDR_RXD` and `count != 0`. The read pointer advances and `count` decrements.
- Pointers wrap modulo `DEPTH`. `count` is `$clog2(DEPTH)+1` bits wide, range 0..`DEPTH`.
- Read data:
  - `ADDR_RXD`: {24'b0, head byte}; 32'h0 when empty, and an empty read pops nothing.
  - `ADDR_CON`: bit0 `IRQ_EN` (rw), bit1 `NONEMPTY` (ro), bit2 `FULL` (ro), bit3 `OVF` (sticky), bits[8:4] `count` (ro), all other bits 0.
  - Any other address: 32'h0.
- Write to `ADDR_CON`: `IRQ_EN <= wdata[0]`. If `wdata[3]` is 1, `OVF` clears. Writes to `ADDR_RXD` are ignored.
- Overflow: a push while full with no simultaneous pop drops the incoming byte and sets `OVF`. The FIFO contents are not modified.
- Push and pop in the same cycle:
  - Both are performed and `count` is unchanged.
  - When full, the push is accepted and `OVF` stays clear.
  - When empty, the pop is void and the push is accepted, so `count` becomes 1.
- If an `OVF` set and a `wdata[3]` clear happen in the same cycle, the set wins.
- `irq = IRQ_EN & NONEMPTY` (combinational).

## Timing
- Reset (asynchronous): pointers = 0, `count` = 0, `IRQ_EN` = 0, `OVF` = 0, `st_d` = 1, storage = 0. As a result `rdata` = 0 for every address and `irq` = 0.
- Reset asserted mid-operation discards all buffered bytes immediately, without waiting for a clock edge.
- Capture latency: a byte pushed at edge N appears on `rdata` (`ADDR_RXD`) and on `NONEMPTY` / `irq` after edge N.
- Read: `rdata` is valid in the same cycle as `rd`. The pop takes effect at the end of that cycle, and the next byte is visible in the following cycle.
- Each `RX_STATUS` high period pushes exactly once, regardless of its length. `RX_STATUS` must be low for at least one `clk` cycle between bytes.
- Sustained input: one byte per `RX_STATUS` pulse. No back-pressure is exerted toward the receiver.

## Configuration
- Macro `UART_RX_FIFO_EN`.
- Defined: FIFO of `DEPTH` entries, behaving as described above.
- Undefined:
  - `DEPTH` is ignored and the block is a single 8-bit holding register. `count` is 0 or 1, and `FULL == NONEMPTY`.
  - Overflow semantics are unchanged: a new byte arriving while the register is occupied and not being read sets `OVF` and is dropped.
  - The register map is otherwise identical.

## Test plan
- Reset then idle: read `ADDR_CON` -> 32'h0; read `ADDR_RXD` -> 32'h0; `irq` = 0.
- Capture: write `ADDR_CON` = 1. Then drive `RX_DATA` = 8'hA5 with `RX_STATUS` high for 5 cycles -> exactly one push. `ADDR_CON` reads 32'h13 and `irq` = 1. Reading `ADDR_RXD` -> 32'hA5, after which `irq` = 0.
- Order/wrap: push 8'h01..8'h04 (`DEPTH` = 4) -> `ADDR_CON` bits[8:4] = 4 and `FULL` = 1. Read 2 bytes, push 8'h05 and 8'h06, then read 4 -> 8'h03, 04, 05, 06 in that order.
- Overflow: fill to 4 bytes, push 8'hEE -> `OVF` = 1 and reads return the original 4 bytes only. Write `ADDR_CON` = 32'h9 -> `OVF` = 0 and `IRQ_EN` = 1.
- Simultaneous events:
  - Full FIFO, push 8'h77 in the same cycle as a read -> `OVF` = 0, `count` stays 4, and 8'h77 is the last byte out.
  - Empty FIFO, push + read in the same cycle -> `rdata` = 0 that cycle, then `count` = 1.
- Reset mid-stream: 3 bytes buffered, pulse `reset` low with `RX_STATUS` held high across release -> `count` = 0 and no push until `RX_STATUS` falls and rises again. Repeat with `UART_RX_FIFO_EN` undefined and confirm a second byte sets `OVF`.
